// File: rtl/lc4_divider_iter_pkg.sv
// Shared constants and state encoding for the 16-bit iterative restoring divider.
package lc4_divider_iter_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/lc4_divider_iter_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a second-level lookahead.
module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [15:0] carry;
  logic [3:0]  groupGen;
  logic [3:0]  groupProp;
  logic [3:0]  groupCarry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_group
      assign groupGen[k]  = gen[4*k+3]
                          | (prop[4*k+3] & gen[4*k+2])
                          | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                          | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      assign groupProp[k] = &prop[4*k +: 4];

      assign carry[4*k]   = groupCarry[k];
      assign carry[4*k+1] = gen[4*k] | (prop[4*k] & groupCarry[k]);
      assign carry[4*k+2] = gen[4*k+1]
                          | (prop[4*k+1] & gen[4*k])
                          | (prop[4*k+1] & prop[4*k] & groupCarry[k]);
      assign carry[4*k+3] = gen[4*k+2]
                          | (prop[4*k+2] & gen[4*k+1])
                          | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                          | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & groupCarry[k]);
    end
  endgenerate

  // Second level: group carries computed directly from cin, not rippled.
  assign groupCarry[0] = cin_i;
  assign groupCarry[1] = groupGen[0] | (groupProp[0] & cin_i);
  assign groupCarry[2] = groupGen[1]
                       | (groupProp[1] & groupGen[0])
                       | (groupProp[1] & groupProp[0] & cin_i);
  assign groupCarry[3] = groupGen[2]
                       | (groupProp[2] & groupGen[1])
                       | (groupProp[2] & groupProp[1] & groupGen[0])
                       | (groupProp[2] & groupProp[1] & groupProp[0] & cin_i);

  assign sum_o = prop ^ carry;

endmodule

// File: rtl/lc4_divider_iter.sv
// Iterative 16-bit unsigned restoring divider: one quotient bit per RUN cycle, valid/ready on both sides.
module lc4_divider_iter
  import lc4_divider_iter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DIV_WIDTH-1:0] o_quotient,
  output logic [DIV_WIDTH-1:0] o_remainder
);

  div_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] dividend_q, dividend_d;
  logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [3:0]           count_q, count_d;
  logic [DIV_WIDTH-1:0] resultQuot_q, resultQuot_d;
  logic [DIV_WIDTH-1:0] resultRem_q, resultRem_d;

  logic [DIV_WIDTH-1:0] shifted;
  logic [DIV_WIDTH-1:0] notDivisor;
  logic [DIV_WIDTH-1:0] diff;
  logic                 shiftOut;
  logic                 carryIn15;
  logic                 carryOut;
  logic                 stepOk;
  logic [DIV_WIDTH-1:0] remNext;
  logic [DIV_WIDTH-1:0] quotNext;

  assign shifted    = {rem_q[DIV_WIDTH-2:0], dividend_q[DIV_WIDTH-1]};
  assign shiftOut   = rem_q[DIV_WIDTH-1];
  assign notDivisor = ~divisor_q;

  cla16 u_cla (
    .a_i   (shifted),
    .b_i   (notDivisor),
    .cin_i (1'b1),
    .sum_o (diff)
  );

  // The adder exposes no carry-out, so rebuild it from the top bit's inputs and sum.
  assign carryIn15 = diff[15] ^ shifted[15] ^ notDivisor[15];
  assign carryOut  = (shifted[15] & notDivisor[15])
                   | (shifted[15] & carryIn15)
                   | (notDivisor[15] & carryIn15);
  assign stepOk    = shiftOut | carryOut;
  assign remNext   = stepOk ? diff : shifted;
  assign quotNext  = {quot_q[DIV_WIDTH-2:0], stepOk};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dividend_q   <= '0;
      divisor_q    <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      count_q      <= '0;
      resultQuot_q <= '0;
      resultRem_q  <= '0;
    end else begin
      state_q      <= state_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      count_q      <= count_d;
      resultQuot_q <= resultQuot_d;
      resultRem_q  <= resultRem_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    count_d      = count_q;
    resultQuot_d = resultQuot_q;
    resultRem_d  = resultRem_q;
    o_ready      = 1'b0;
    o_valid      = 1'b0;

    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          dividend_d = i_dividend;
          divisor_d  = i_divisor;
          rem_d      = '0;
          quot_d     = '0;
          count_d    = 4'd15;
          if (i_divisor == '0) begin
            state_d      = DONE;
            resultQuot_d = '0;
            resultRem_d  = '0;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        dividend_d = {dividend_q[DIV_WIDTH-2:0], 1'b0};
        rem_d      = remNext;
        quot_d     = quotNext;
        if (count_q == 4'd0) begin
          state_d      = DONE;
          resultQuot_d = quotNext;
          resultRem_d  = remNext;
        end else begin
          count_d = count_q - 4'd1;
        end
      end

      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Separate result registers keep the outputs frozen while the working registers iterate.
  assign o_quotient  = resultQuot_q;
  assign o_remainder = resultRem_q;

endmodule
